bin2bcd_4dig: RTL

//  Sequential binary-to-BCD converter (shift-add-3, one bit per clk) feeding the 4-digit
//  7-seg multiplexer with units/tens/hundreds/thousands. Lets counters and sensor values be

---
 rtl/bin2bcd_4dig.sv | 108 ++++++++++
 1 files changed

// File: rtl/bin2bcd_4dig.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) for a 4-digit display.
// Digits, blank mask and overflow flag update only when a conversion completes.
module bin2bcd_4dig #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [3:0]       units,
    output logic [3:0]       tens,
    output logic [3:0]       hundreds,
    output logic [3:0]       thousands,
    output logic [3:0]       blank,
    output logic             ovf
);

    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    logic [BIN_W-1:0]   shift_reg;
    logic [15:0]        scratch;
    logic [CNT_W-1:0]   bit_cnt;
    logic               ovf_nxt;

    logic [15:0]        scratch_adj;
    logic [15+BIN_W:0]  pair_shifted;
    logic [15:0]        digits_nxt;
    logic [3:0]         blank_nxt;

    // Carry out of the top nibble falls off the shift; saturation covers those values.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        pair_shifted = {scratch_adj, shift_reg} << 1;
        digits_nxt   = ovf_nxt ? 16'h9999 : scratch;
        blank_nxt[3] = (digits_nxt[15:12] == 4'd0);
        blank_nxt[2] = blank_nxt[3] & (digits_nxt[11:8] == 4'd0);
        blank_nxt[1] = blank_nxt[2] & (digits_nxt[7:4] == 4'd0);
        blank_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            scratch   <= '0;
            bit_cnt   <= '0;
            ovf_nxt   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            units     <= 4'd0;
            tens      <= 4'd0;
            hundreds  <= 4'd0;
            thousands <= 4'd0;
            blank     <= 4'b1110;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= bin;
                        scratch   <= '0;
                        bit_cnt   <= '0;
                        ovf_nxt   <= (32'(bin) > 32'd9999);
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch, shift_reg} <= pair_shifted;
                    bit_cnt              <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(BIN_W - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    thousands <= digits_nxt[15:12];
                    hundreds  <= digits_nxt[11:8];
                    tens      <= digits_nxt[7:4];
                    units     <= digits_nxt[3:0];
                    blank     <= blank_nxt;
                    ovf       <= ovf_nxt;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
